// File: rtl/prog_ctr_pkg.sv
// rtl/prog_ctr_pkg.sv - shared state enum, widths and branch-target table for prog_ctr (BRANCH_REL_EN selects entry type)
package prog_ctr_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_LUT_IDX_W = 5;
    localparam int LUT_DEPTH     = 1 << DEF_LUT_IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef BRANCH_REL_EN
    // Entries are signed offsets added to the current fetch address.
    typedef logic signed [7:0] lut_entry_t;

    localparam lut_entry_t BRANCH_TABLE [0:LUT_DEPTH-1] = '{
         8'sd1,   -8'sd1,   -8'sd3,    8'sd0,   8'sd127, -8'sd128,   8'sd5,   -8'sd5,
         8'sd10,  -8'sd10,   8'sd2,   -8'sd2,   8'sd64,  -8'sd64,    8'sd3,   -8'sd7,
         8'sd20,  -8'sd20,   8'sd100, -8'sd100, 8'sd8,   -8'sd8,     8'sd16,  -8'sd16,
         8'sd30,  -8'sd30,   8'sd4,   -8'sd4,   8'sd0,    8'sd1,    -8'sd1,    8'sd6
    };
`else
    // Entries are absolute fetch addresses.
    typedef logic [DEF_ADDR_W-1:0] lut_entry_t;

    localparam lut_entry_t BRANCH_TABLE [0:LUT_DEPTH-1] = '{
        10'd16,  10'd100, 10'd40,  10'd1023, 10'd512, 10'd0,   10'd7,    10'd300,
        10'd9,   10'd12,  10'd5,   10'd1000, 10'd255, 10'd256, 10'd511,  10'd768,
        10'd33,  10'd64,  10'd128, 10'd200,  10'd400, 10'd600, 10'd800,  10'd900,
        10'd1,   10'd2,   10'd3,   10'd4,    10'd1022, 10'd700, 10'd50,  10'd999
    };
`endif

endpackage

// File: rtl/prog_ctr_branch_lut.sv
// rtl/prog_ctr_branch_lut.sv - combinational branch-target table lookup (entry type set by BRANCH_REL_EN)
module branch_lut
    import prog_ctr_pkg::*;
(
    input  logic [DEF_LUT_IDX_W-1:0] lut_idx,
    output lut_entry_t               entry
);

    // Pure table read; interpretation of the entry is left to the caller.
    assign entry = BRANCH_TABLE[lut_idx];

endmodule

// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter and start/halt run control; BRANCH_REL_EN selects relative branch targets
module prog_ctr
    import prog_ctr_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LUT_IDX_W = DEF_LUT_IDX_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Halt,
    input  logic                 Stall,
    input  logic                 BranchEn,
    input  logic [7:0]           AluOut,
    input  logic [LUT_IDX_W-1:0] LutIdx,
    output logic [ADDR_W-1:0]    ProgCtr,
    output logic                 Running,
    output logic                 Done
);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] target;
    lut_entry_t        lut_entry;
    logic              unused_alu;

    // Only the compare bit of the ALU result steers the branch.
    assign unused_alu = ^AluOut[7:1];

    branch_lut u_branch_lut (
        .lut_idx (LutIdx),
        .entry   (lut_entry)
    );

`ifdef BRANCH_REL_EN
    // Sign-extend the offset; the add wraps naturally at the address width.
    assign target = pc_q + {{(ADDR_W-8){lut_entry[7]}}, lut_entry};
`else
    assign target = ADDR_W'(lut_entry);
`endif

    // State and fetch-address registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
        end
    end

    // Next state and next fetch address; Halt > Stall > taken branch > increment.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        case (state_q)
            IDLE: begin
                pc_n = '0;
                if (Start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_n = DONE;
                end else if (Stall) begin
                    pc_n = pc_q;
                end else if (BranchEn && AluOut[0]) begin
                    pc_n = target;
                end else begin
                    pc_n = pc_q + 1'b1;
                end
            end
            DONE: begin
                if (Start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = '0;
            end
        endcase
    end

    assign ProgCtr = pc_q;
    assign Running = (state_q == RUN);
    assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_prog_ctr.sv
// tb/tb_prog_ctr.sv - scoreboard bench for prog_ctr against a behavioural run-control model (honours BRANCH_REL_EN)
module tb_prog_ctr;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Halt = 1'b0;
    logic       Stall = 1'b0;
    logic       BranchEn = 1'b0;
    logic [7:0] AluOut = 8'h00;
    logic [4:0] LutIdx = 5'd0;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;

    prog_ctr dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Halt     (Halt),
        .Stall    (Stall),
        .BranchEn (BranchEn),
        .AluOut   (AluOut),
        .LutIdx   (LutIdx),
        .ProgCtr  (ProgCtr),
        .Running  (Running),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int pc;
        bit run;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Independent copy of the branch table, as the program would see it.
`ifdef BRANCH_REL_EN
    int table_v [32] = '{1, -1, -3, 0, 127, -128, 5, -5, 10, -10, 2, -2, 64, -64, 3, -7,
                         20, -20, 100, -100, 8, -8, 16, -16, 30, -30, 4, -4, 0, 1, -1, 6};
`else
    int table_v [32] = '{16, 100, 40, 1023, 512, 0, 7, 300, 9, 12, 5, 1000, 255, 256, 511, 768,
                         33, 64, 128, 200, 400, 600, 800, 900, 1, 2, 3, 4, 1022, 700, 50, 999};
`endif

    // Model: "running", "finished" flags and an integer address.
    bit m_running = 0;
    bit m_finished = 0;
    int m_pc = 0;

    function automatic int branch_target(input int pc, input int idx);
`ifdef BRANCH_REL_EN
        return (((pc + table_v[idx]) % 1024) + 1024) % 1024;
`else
        return table_v[idx];
`endif
    endfunction

    task automatic step(input bit rst, input bit st, input bit hl, input bit sl,
                        input bit be, input logic [7:0] alu, input logic [4:0] idx);
        exp_t e;
        @(negedge Clk);
        Reset = rst; Start = st; Halt = hl; Stall = sl;
        BranchEn = be; AluOut = alu; LutIdx = idx;
        if (rst) begin
            m_running = 0; m_finished = 0; m_pc = 0;
        end else if (m_running) begin
            if (hl) begin
                m_running = 0; m_finished = 1;
            end else if (sl) begin
                m_pc = m_pc;
            end else if (be && alu[0]) begin
                m_pc = branch_target(m_pc, int'(idx));
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end else if (st) begin
            m_running = 1; m_finished = 0; m_pc = 0;
        end
        e.pc = m_pc; e.run = m_running; e.done = m_finished;
        exp_q.push_back(e);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 8'h00, 5'd0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 1100 && m_pc != target; i++) begin
            idle_step();
        end
    endtask

    // Monitor: one registered output set per clock, checked after the edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (int'(ProgCtr) != e.pc) begin
                bad++;
                $display("FAIL progctr t=%0t got=%0d want=%0d", $time, ProgCtr, e.pc);
            end
            total++;
            if (Running !== e.run) begin
                bad++;
                $display("FAIL running t=%0t got=%b want=%b", $time, Running, e.run);
            end
            total++;
            if (Done !== e.done) begin
                bad++;
                $display("FAIL done t=%0t got=%b want=%b", $time, Done, e.done);
            end
        end
    end

    initial begin
        bit st, hl, sl, be, rs;
        int waited;

        step(1, 0, 0, 0, 0, 8'h00, 5'd0);
        step(1, 1, 1, 1, 1, 8'hFF, 5'd2);
        idle_step();
        step(0, 0, 1, 1, 1, 8'h01, 5'd2);

        step(0, 1, 0, 0, 0, 8'h00, 5'd0);
        idle_step(); idle_step(); idle_step();
        step(0, 1, 0, 0, 0, 8'h00, 5'd0);

        run_to(5);
        step(0, 0, 0, 0, 1, 8'h01, 5'd2);

        step(1, 0, 0, 0, 0, 8'h00, 5'd0);
        step(0, 1, 0, 0, 0, 8'h00, 5'd0);
        run_to(7);
        step(0, 0, 0, 0, 1, 8'hFE, 5'd2);
        step(0, 0, 0, 0, 1, 8'hFE, 5'd3);
        run_to(12);
        step(0, 0, 1, 0, 1, 8'h01, 5'd2);
        step(0, 0, 1, 1, 1, 8'h01, 5'd3);
        idle_step();
        step(0, 1, 0, 0, 0, 8'h00, 5'd0);
        idle_step();

        run_to(9);
        step(0, 0, 0, 1, 1, 8'h01, 5'd2);
        step(0, 0, 0, 1, 0, 8'h00, 5'd0);
        step(0, 0, 0, 1, 0, 8'h00, 5'd0);
        idle_step();

        run_to(300);
        step(1, 1, 1, 0, 1, 8'h01, 5'd2);
        step(0, 1, 0, 0, 0, 8'h00, 5'd0);
        run_to(1023);
        idle_step();
        idle_step();

        // Tight self-loop: absolute entry 9 is 12, relative entry 3 is 0.
        run_to(12);
`ifdef BRANCH_REL_EN
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h03, 5'd3);
`else
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h03, 5'd9);
`endif

        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(99) < 2);
            st = ($urandom_range(99) < 15);
            hl = ($urandom_range(99) < 4);
            sl = ($urandom_range(99) < 20);
            be = ($urandom_range(99) < 35);
            step(rs, st, hl, sl, be, 8'($urandom), 5'($urandom));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_ctr.md
# prog_ctr

Program counter and run-control stage that sits directly downstream of the ALU in the 8-bit custom-ISA core. Each cycle it advances the fetch address, or redirects it to a branch target when the decoder flags a branch (opcode 110) and the ALU's compare result is 1. It owns the core's start/halt handshake with the testbench/host. Branch targets come from a small lookup table indexed by an instruction field.

## Interface
- ADDR_W, 10, width of the instruction address / ProgCtr
- LUT_IDX_W, 5, width of the branch-target LUT index
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; forces IDLE state
- Start  in  1  level; 1 for one or more cycles launches a program run
- Halt  in  1  from decoder; current instruction is the halt instruction
- Stall  in  1  hold ProgCtr this cycle (multi-cycle memory op)
- BranchEn  in  1  from decoder; current instruction is a branch (ALU op 110)
- AluOut  in  8  ALU result; bit 0 is the branch condition
- LutIdx  in  LUT_IDX_W  branch-target table index from the instruction word
- ProgCtr  out  ADDR_W  current fetch address; reset 0
- Running  out  1  1 while in RUN; reset 0
- Done  out  1  1 while in DONE; reset 0

## Operation
- States: IDLE, RUN, DONE. Encoded as an enum in the package. Reset value: IDLE.
- IDLE: ProgCtr held at 0. When Start=1, go to RUN; ProgCtr stays 0.
- RUN: updates ProgCtr by strict priority, highest first:
  - Halt=1: go to DONE; ProgCtr frozen at the halt instruction's address.
  - Stall=1: ProgCtr held.
  - BranchEn=1 and AluOut[0]=1: ProgCtr = branch target.
  - Otherwise: ProgCtr = ProgCtr + 1.
- BranchEn=1 with AluOut[0]=0: not taken; ProgCtr + 1.
- AluOut[7:1] is ignored.
- DONE: ProgCtr and Done held. When Start=1, go to RUN with ProgCtr = 0; Done drops in the same cycle.
- Start while in RUN: ignored.
- Halt, Stall and BranchEn are ignored outside RUN.
- Increment wraps modulo 2^ADDR_W (e.g. 1023 → 0). No flag is raised.
- Branch target arithmetic is modulo 2^ADDR_W. A target equal to the current ProgCtr is legal, and taking it repeatedly produces a tight loop.

## Timing
- Single-cycle redirect: a branch decision made from AluOut in cycle N appears on ProgCtr after the edge ending cycle N. There is no delay slot.
- Outputs are registered; Running and Done are decoded from the state register.
- Reset mid-run: on the next edge, state is IDLE, ProgCtr=0, Running=0, Done=0, regardless of the other inputs.
- Halt and a taken branch in the same cycle: Halt wins.
- Stall and a taken branch in the same cycle: Stall wins. The decoder must hold BranchEn/LutIdx until Stall releases.
- Start and Reset in the same cycle: Reset wins.

## Configuration
- BRANCH_REL_EN defined: LUT entries are 8-bit signed offsets. Target = ProgCtr + sign_extend(entry), modulo 2^ADDR_W.
- BRANCH_REL_EN undefined: LUT entries are ADDR_W-bit absolute addresses. Target = entry.
- The state machine and priorities are identical in both builds.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - ADDR_W and LUT_IDX_W defaults;
  - the branch-target table constant, with its entry type selected by BRANCH_REL_EN.
- Sub-module branch_lut: purely combinational. Input LutIdx; output the entry (offset or absolute). prog_ctr instantiates it and does the add/select.

## Test plan
- Reset, then Start=1 for 1 cycle → Running=1, ProgCtr sequence 0,1,2,3 on successive edges; Done=0.
- ProgCtr=5, BranchEn=1, AluOut=8'h01, LutIdx=2:
  - absolute build, table[2]=40 → next ProgCtr=40;
  - BRANCH_REL_EN build, table[2]=-3 → next ProgCtr=2.
- BranchEn=1, AluOut=8'hFE (bit0=0) at ProgCtr=7 → next ProgCtr=8.
- Halt=1 with BranchEn=1, AluOut=1 at ProgCtr=12 → DONE, ProgCtr stays 12, Done=1, Running=0. A later Start=1 → ProgCtr=0, Running=1.
- ProgCtr=1023 with no branch → next 0. Stall=1 for 3 cycles at ProgCtr=9 → ProgCtr stays 9, then resumes at 10.
- Reset=1 asserted while running at ProgCtr=300 → next edge ProgCtr=0, IDLE, Running=0, Done=0.
